// File: rtl/riscv_pkg.sv
// Shared RV32 constants plus the data-memory controller's MMIO map and response types.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] DMEM_LED_OFS    = 4'h0;
  localparam logic [3:0] DMEM_CYC_OFS    = 4'h4;
  localparam logic [3:0] DMEM_TOHOST_OFS = 4'h8;

  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] rdata;
  } dmem_rsp_t;

  // One load-pipeline stage; stores and faults travel as F3_LW with a zero word.
  typedef struct packed {
    logic        fault;
    logic [2:0]  funct3;
    logic [1:0]  ofs;
    logic [31:0] word;
  } dmem_stage_t;

  function automatic logic [3:0] dmem_be(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3[1:0])
      2'b00:   return 4'b0001 << ofs;
      2'b01:   return 4'b0011 << ofs;
      default: return 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(parameter int XLEN = 32, parameter int ALEN = 32) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [ALEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_fault);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_fault);
endinterface

// File: rtl/dmem_load_format.sv
// Lane select and sign/zero extension of the final load-pipeline stage.
module dmem_load_format
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ofs,
  input  logic [31:0] word,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  assign sh = word >> {ofs, 3'b000};

  always_comb begin
    rdata = word;
    case (funct3)
      F3_LB:   rdata = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  rdata = {24'h0, sh[7:0]};
      F3_LH:   rdata = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  rdata = {16'h0, sh[15:0]};
      default: rdata = word;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: RAM + MMIO (LEDs, cycle counter, tohost), in-order fixed-latency responses.
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned accesses instead of returning 32'hDEAD_BEEF.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              ALEN        = 32,
  parameter int              DEPTH_WORDS = 1048576,
  parameter int              RD_LATENCY  = 1,
  parameter int              LED_W       = 4,
  parameter logic [ALEN-1:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_ctrl_if.slave       bus,
  output logic [LED_W-1:0] leds_out,
  output logic             halt,
  output logic [XLEN-1:0]  halt_code
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [XLEN-1:0]       mem [DEPTH_WORDS];
  logic [XLEN-1:0]       cyc;
  logic                  acc, mis, mmio_hit, ram_hit;
  logic                  ram_we, led_we, tohost_we;
  logic [1:0]            ofs, mreg;
  logic [3:0]            be;
  logic [XLEN-1:0]       wdata_sh;
  logic [AW-1:0]         idx;
  dmem_stage_t           cap;
  dmem_stage_t           stg [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [31:0]           fmt_data;
  dmem_rsp_t             rsp;

  assign bus.req_ready = rst_n & ~halt;
  assign acc      = bus.req_valid & bus.req_ready;
  assign ofs      = bus.req_addr[1:0];
  assign mreg     = bus.req_addr[3:2];
  assign mis      = (bus.req_funct3[1:0] == 2'b01 && ofs[0]) ||
                    (bus.req_funct3[1]   && ofs != 2'b00);
  assign mmio_hit = bus.req_addr[ALEN-1:4] == MMIO_BASE[ALEN-1:4];
  assign ram_hit  = (bus.req_addr >> 2) < ALEN'(DEPTH_WORDS);
  assign idx      = bus.req_addr[AW+1:2];
  assign be       = dmem_be(bus.req_funct3, ofs);
  assign wdata_sh = bus.req_wdata << {ofs, 3'b000};

  // Decode in priority order: misaligned, MMIO, RAM, unmapped.
  always_comb begin
    cap        = '0;
    cap.funct3 = bus.req_funct3;
    cap.ofs    = ofs;
    ram_we     = 1'b0;
    led_we     = 1'b0;
    tohost_we  = 1'b0;
    if (mis) begin
      cap.funct3 = F3_LW;
      cap.ofs    = '0;
`ifdef DMEM_MISALIGN_FAULT_EN
      cap.fault  = 1'b1;
`else
      if (!bus.req_we) cap.word = 32'hDEAD_BEEF;
`endif
    end else if (mmio_hit) begin
      if (bus.req_we) begin
        led_we    = (mreg == DMEM_LED_OFS[3:2]);
        tohost_we = (mreg == DMEM_TOHOST_OFS[3:2]);
      end else if (mreg == DMEM_LED_OFS[3:2]) begin
        cap.word = 32'(leds_out);
      end else if (mreg == DMEM_CYC_OFS[3:2]) begin
        cap.word = cyc;
      end
    end else if (ram_hit) begin
      if (bus.req_we) ram_we = 1'b1;
      else            cap.word = mem[idx];
    end else begin
      cap.fault  = 1'b1;
      cap.funct3 = F3_LW;
      cap.ofs    = '0;
    end
    if (bus.req_we) begin
      cap.funct3 = F3_LW;
      cap.ofs    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && ram_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    stg[0] <= cap;
    for (int i = 1; i < RD_LATENCY; i++) stg[i] <= stg[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= '0;
      leds_out  <= '0;
      halt      <= 1'b0;
      halt_code <= '0;
      vld_pipe  <= '0;
    end else begin
      cyc      <= cyc + 1'b1;
      vld_pipe <= RD_LATENCY'({vld_pipe, acc});
      if (acc && led_we && be[0]) leds_out <= wdata_sh[LED_W-1:0];
      if (acc && tohost_we) begin
        halt      <= 1'b1;
        halt_code <= bus.req_wdata;
      end
    end
  end

  dmem_load_format u_fmt (
    .funct3 (stg[RD_LATENCY-1].funct3),
    .ofs    (stg[RD_LATENCY-1].ofs),
    .word   (stg[RD_LATENCY-1].word),
    .rdata  (fmt_data)
  );

  always_comb begin
    rsp = '0;
    if (vld_pipe[RD_LATENCY-1]) begin
      rsp.valid = 1'b1;
      rsp.fault = stg[RD_LATENCY-1].fault;
      rsp.rdata = fmt_data;
    end
  end

  assign bus.rsp_valid = rsp.valid;
  assign bus.rsp_fault = rsp.fault;
  assign bus.rsp_rdata = rsp.rdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-level reference model + per-cycle compare, plus literal spot checks.
module tb_dmem_ctrl;
  localparam int          DEPTH = 1024;
  localparam int          RDL   = 3;
  localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef DMEM_MISALIGN_FAULT_EN
  localparam bit MISF = 1'b1;
`else
  localparam bit MISF = 1'b0;
`endif

  typedef struct { int t; logic f; logic [31:0] d; } rec_t;

  logic        clk, rst_n;
  logic [3:0]  leds_out;
  logic        halt;
  logic [31:0] halt_code;

  dmem_ctrl_if #(.XLEN(32), .ALEN(32)) bus ();

  dmem_ctrl #(.XLEN(32), .ALEN(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(RDL),
              .LED_W(4), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .leds_out(leds_out), .halt(halt), .halt_code(halt_code));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks, errors, tick;
  logic [7:0]  mem_b [DEPTH*4];
  logic [3:0]  led_m;
  logic        halt_m;
  logic [31:0] code_m, cyc_m;
  bit          exp_v [int];
  bit          exp_f [int];
  logic [31:0] exp_d [int];
  rec_t        rsp_q [$];
  logic [31:0] ma, mwd, mval, md;
  logic [2:0]  mf3;
  logic        mwe, mfault;
  int          mnb, mofs;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] v, input int nb, input logic uns);
    if (nb == 1) return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (nb == 2) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int ta);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk);
    ta = tick;
    #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic get_rsp(output rec_t r);
    int n = 0;
    while (rsp_q.size() == 0 && n < 30) begin @(posedge clk); #1; n++; end
    if (rsp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout got none exp response");
      r = '{-1, 1'bx, 32'hx};
    end else r = rsp_q.pop_front();
  endtask

  task automatic acc_chk(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_dat, input logic exp_flt);
    int ta; rec_t r;
    issue(we, f3, a, d, ta);
    get_rsp(r);
    check({nm, "_data"}, r.d, exp_dat);
    check({nm, "_fault"}, 32'(r.f), 32'(exp_flt));
  endtask

  initial begin
    int ta0, tx; rec_t r; logic [31:0] c1;
    checks = 0; errors = 0; tick = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = '0; bus.req_wdata = '0;
    fork
      forever begin : model
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          led_m = '0; halt_m = 1'b0; code_m = '0; cyc_m = '0;
          exp_v.delete(); exp_f.delete(); exp_d.delete();
        end else begin
          if (bus.req_valid && !halt_m) begin
            ma = bus.req_addr; mwd = bus.req_wdata; mf3 = bus.req_funct3; mwe = bus.req_we;
            mnb = (mf3[1:0] == 2'b00) ? 1 : (mf3[1:0] == 2'b01) ? 2 : 4;
            mofs = int'(ma[1:0]); mfault = 1'b0; md = '0;
            if ((mofs % mnb) != 0) begin
              mfault = MISF;
              md = (MISF || mwe) ? 32'h0 : 32'hDEAD_BEEF;
            end else if (ma >= BASE && ma < BASE + 32'd16) begin
              case ((ma - BASE) >> 2)
                0:       mval = {28'h0, led_m};
                1:       mval = cyc_m;
                default: mval = '0;
              endcase
              if (mwe) begin
                if (ma == BASE) led_m = mwd[3:0];
                if (ma - BASE >= 32'd8 && ma - BASE < 32'd12) begin halt_m = 1'b1; code_m = mwd; end
              end else md = ext(mval >> (8*mofs), mnb, mf3[2]);
            end else if ((ma >> 2) < 32'(DEPTH)) begin
              if (mwe) for (int i = 0; i < mnb; i++) mem_b[int'(ma)+i] = mwd[8*i +: 8];
              else begin
                mval = '0;
                for (int i = 0; i < mnb; i++) mval = mval | (32'(mem_b[int'(ma)+i]) << (8*i));
                md = ext(mval, mnb, mf3[2]);
              end
            end else mfault = 1'b1;
            exp_v[tick+RDL-1] = 1'b1; exp_f[tick+RDL-1] = mfault; exp_d[tick+RDL-1] = md;
          end
          cyc_m = cyc_m + 1;
        end
      end
      forever begin : compare
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(rst_n && !halt_m));
        if (!rst_n) begin
          check("rst_rsp_fault", 32'(bus.rsp_fault), 32'h0);
          check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        end
        if (exp_v.exists(tick)) begin
          check("rsp_valid", 32'(bus.rsp_valid), 32'h1);
          check("rsp_fault", 32'(bus.rsp_fault), 32'(exp_f[tick]));
          check("rsp_rdata", bus.rsp_rdata, exp_d[tick]);
          exp_v.delete(tick);
        end else check("rsp_idle", 32'(bus.rsp_valid), 32'h0);
        if (bus.rsp_valid) rsp_q.push_back('{tick, bus.rsp_fault, bus.rsp_rdata});
        check("leds_out", 32'(leds_out), 32'(led_m));
        check("halt", 32'(halt), 32'(halt_m));
        check("halt_code", halt_code, code_m);
        tick++;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds_out), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    acc_chk("sw100",  1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 0);
    acc_chk("sw104",  1, 3'b010, 32'h104, 32'h1111_1111, 32'h0, 0);
    acc_chk("lb103",  0, 3'b000, 32'h103, 32'h0, 32'h0000_0012, 0);
    acc_chk("lbu103", 0, 3'b100, 32'h103, 32'h0, 32'h0000_0012, 0);
    acc_chk("lb102",  0, 3'b000, 32'h102, 32'h0, 32'h0000_0034, 0);
    acc_chk("lh102",  0, 3'b001, 32'h102, 32'h0, 32'h0000_1234, 0);
    acc_chk("sb101",  1, 3'b000, 32'h101, 32'hFF, 32'h0, 0);
    acc_chk("lw100",  0, 3'b010, 32'h100, 32'h0, 32'h1234_FF78, 0);
    acc_chk("lb101",  0, 3'b000, 32'h101, 32'h0, 32'hFFFF_FFFF, 0);
    acc_chk("lbu101", 0, 3'b100, 32'h101, 32'h0, 32'h0000_00FF, 0);

    // Four back-to-back loads: responses on consecutive cycles, RDL-1 ticks after accept.
    issue(0, 3'b010, 32'h100, 32'h0, ta0);
    issue(0, 3'b100, 32'h100, 32'h0, tx);
    issue(0, 3'b001, 32'h100, 32'h0, tx);
    issue(0, 3'b101, 32'h102, 32'h0, tx);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want [4];
      want[0] = 32'h1234_FF78; want[1] = 32'h0000_0078;
      want[2] = 32'hFFFF_FF78; want[3] = 32'h0000_1234;
      get_rsp(r);
      check("b2b_timing", 32'(r.t - ta0), 32'(i + 2));
      check("b2b_data", r.d, want[i]);
    end

    acc_chk("mis_lw101", 0, 3'b010, 32'h101, 32'h0, MISF ? 32'h0 : 32'hDEAD_BEEF, MISF);
    acc_chk("mis_sw101", 1, 3'b010, 32'h101, 32'hCAFE_BABE, 32'h0, MISF);
    acc_chk("mis_lw100", 0, 3'b010, 32'h100, 32'h0, 32'h1234_FF78, 0);
    acc_chk("mis_lw104", 0, 3'b010, 32'h104, 32'h0, 32'h1111_1111, 0);

    acc_chk("led_sw", 1, 3'b010, BASE, 32'hA, 32'h0, 0);
    check("led_val", 32'(leds_out), 32'hA);
    acc_chk("led_lw", 0, 3'b010, BASE, 32'h0, 32'hA, 0);
    acc_chk("cyc_sw", 1, 3'b010, BASE + 32'h4, 32'h55, 32'h0, 0);
    acc_chk("rsv_lw", 0, 3'b010, BASE + 32'hC, 32'h0, 32'h0, 0);
    issue(0, 3'b010, BASE + 32'h4, 32'h0, tx);
    repeat (4) begin @(posedge clk); #1; end
    issue(0, 3'b010, BASE + 32'h4, 32'h0, tx);
    get_rsp(r); c1 = r.d;
    get_rsp(r);
    check("cyc_delta", r.d - c1, 32'd5);

    acc_chk("oob_lw",   0, 3'b010, 32'(DEPTH*4), 32'h0, 32'h0, 1);
    acc_chk("last_sw",  1, 3'b010, 32'(DEPTH*4-4), 32'h5A5A_A5A5, 32'h0, 0);
    acc_chk("last_lw",  0, 3'b010, 32'(DEPTH*4-4), 32'h0, 32'h5A5A_A5A5, 0);

    // Reset with two loads in flight.
    issue(0, 3'b010, 32'h100, 32'h0, tx);
    issue(0, 3'b010, 32'h104, 32'h0, tx);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("rst_inflight", 32'(rsp_q.size()), 32'h0);
    check("rst_leds_mid", 32'(leds_out), 32'h0);
    acc_chk("post_rst_lw", 0, 3'b010, 32'h100, 32'h0, 32'h1234_FF78, 0);

    acc_chk("tohost", 1, 3'b010, BASE + 32'h8, 32'h1, 32'h0, 0);
    check("halt_set", 32'(halt), 32'h1);
    check("halt_code1", halt_code, 32'h1);
    check("halt_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
    repeat (5) begin @(posedge clk); #1; end
    bus.req_valid = 1'b0;
    check("halt_no_rsp", 32'(rsp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
